// File: rtl/c3po_seg_reasm_if.sv
// c3po_seg_reasm_if
//   Bundles the segment input stream and the descriptor output stream of
//   c3po_seg_reasm.
//   Segment side : i_val, i_sop, i_eop, i_vbc[5:0], i_data[SEG_BYTES*8-1:0]
//                  -> block, i_ready <- block
//   Descriptor   : d_val, d_len, d_nseg, d_sum, d_err <- block,
//                  d_ready -> block
//   master = upstream producer / descriptor consumer, slave = the block.
interface c3po_seg_reasm_if #(
  parameter int SEG_BYTES = 32,
  parameter int LEN_W     = 16,
  parameter int NSEG_W    = 8
);
  logic                   i_val;
  logic                   i_sop;
  logic                   i_eop;
  logic [5:0]             i_vbc;
  logic [SEG_BYTES*8-1:0] i_data;
  logic                   i_ready;

  logic                   d_val;
  logic                   d_ready;
  logic [LEN_W-1:0]       d_len;
  logic [NSEG_W-1:0]      d_nseg;
  logic [LEN_W-1:0]       d_sum;
  logic                   d_err;

  modport master (
    output i_val, i_sop, i_eop, i_vbc, i_data, d_ready,
    input  i_ready, d_val, d_len, d_nseg, d_sum, d_err
  );

  modport slave (
    input  i_val, i_sop, i_eop, i_vbc, i_data, d_ready,
    output i_ready, d_val, d_len, d_nseg, d_sum, d_err
  );
endinterface

// File: rtl/c3po_seg_reasm.sv
// c3po_seg_reasm
//   Reassembles the c3po segment stream into packets and queues one
//   descriptor per packet (byte length, segment count, 16-bit byte sum,
//   error flag) in a small FIFO.
// Ports
//   clk, reset        clock and synchronous active-high reset
//   bus (slave)       segment input + descriptor output, see c3po_seg_reasm_if
//   st_pkts, st_drops packet / drop statistics
// Configuration
//   C3PO_REASM_STATS_EN : when defined, st_pkts/st_drops are live 32-bit
//   wrapping counters; otherwise both are tied to zero.
//
// state    | meaning
// ---------+---------------------------------------------------
// S_IDLE   | between packets, waiting for a sop segment
// S_IN_PKT | sop seen, accumulating segments until eop
module c3po_seg_reasm #(
  parameter int SEG_BYTES  = 32,
  parameter int LEN_W      = 16,
  parameter int NSEG_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  c3po_seg_reasm_if.slave     bus,
  output logic [31:0]         st_pkts,
  output logic [31:0]         st_drops
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_IN_PKT} state_t;

  typedef struct packed {
    logic              err;
    logic [LEN_W-1:0]  sum;
    logic [NSEG_W-1:0] nseg;
    logic [LEN_W-1:0]  len;
  } desc_t;

  state_t           r_state, w_state_nxt;
  desc_t            r_acc, w_base, w_desc, w_head;
  desc_t            r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count, w_count_nxt;
  logic             r_ready;
  logic             w_accept, w_push, w_pop, w_drop, w_vbc_ok;
  logic [LEN_W-1:0] w_seg_len, w_seg_sum;
  logic [LEN_W:0]   w_len_add;
  logic [NSEG_W:0]  w_nseg_add;

  // i_ready comes straight from a flop, so d_ready never reaches it combinationally.
  assign bus.i_ready = r_ready;
  assign bus.d_val   = (r_count != '0);
  assign w_accept    = bus.i_val & r_ready;
  assign w_pop       = bus.d_val & bus.d_ready;

  assign w_vbc_ok  = (bus.i_vbc != 6'd0) && (32'(bus.i_vbc) <= SEG_BYTES);
  assign w_seg_len = w_vbc_ok ? LEN_W'(bus.i_vbc) : '0;

  always_comb begin
    w_seg_sum = '0;
    for (int k = 0; k < SEG_BYTES; k++) begin
      if (w_vbc_ok && (k < int'(bus.i_vbc)))
        w_seg_sum = w_seg_sum + LEN_W'(bus.i_data[8*k +: 8]);
    end
  end

  // A sop segment always starts from clean accumulators, which also covers
  // the abort-and-restart case inside a packet.
  always_comb begin
    w_base      = bus.i_sop ? '0 : r_acc;
    w_len_add   = {1'b0, w_base.len} + {1'b0, w_seg_len};
    w_nseg_add  = {1'b0, w_base.nseg} + {{NSEG_W{1'b0}}, 1'b1};
    w_desc.len  = w_len_add[LEN_W]   ? '1 : w_len_add[LEN_W-1:0];
    w_desc.nseg = w_nseg_add[NSEG_W] ? '1 : w_nseg_add[NSEG_W-1:0];
    w_desc.sum  = w_base.sum + w_seg_sum;
    w_desc.err  = w_base.err | ~w_vbc_ok | w_len_add[LEN_W] | w_nseg_add[NSEG_W];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (!bus.i_sop)     w_drop      = 1'b1;
          else if (bus.i_eop) w_push      = 1'b1;
          else                w_state_nxt = S_IN_PKT;
        end
        S_IN_PKT: begin
          w_drop = bus.i_sop;
          if (bus.i_eop) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_count_nxt = r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && (w_state_nxt == S_IN_PKT)) r_acc <= w_desc;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != (PTR_W+1)'(FIFO_DEPTH));
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_desc;
  end

  assign w_head      = r_fifo[r_rd_ptr];
  assign bus.d_len   = bus.d_val ? w_head.len  : '0;
  assign bus.d_nseg  = bus.d_val ? w_head.nseg : '0;
  assign bus.d_sum   = bus.d_val ? w_head.sum  : '0;
  assign bus.d_err   = bus.d_val ? w_head.err  : 1'b0;

`ifdef C3PO_REASM_STATS_EN
  logic [31:0] r_st_pkts, r_st_drops;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st_pkts  <= '0;
      r_st_drops <= '0;
    end else begin
      if (w_push) r_st_pkts  <= r_st_pkts + 32'd1;
      if (w_drop) r_st_drops <= r_st_drops + 32'd1;
    end
  end

  assign st_pkts  = r_st_pkts;
  assign st_drops = r_st_drops;
`else
  logic w_unused;
  assign w_unused = w_drop;
  assign st_pkts  = '0;
  assign st_drops = '0;
`endif
endmodule

// File: tb/tb_c3po_seg_reasm.sv
module tb_c3po_seg_reasm;
  localparam int SB    = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] st_pkts, st_drops;

  c3po_seg_reasm_if #(.SEG_BYTES(SB), .LEN_W(16), .NSEG_W(8)) bus ();

  c3po_seg_reasm #(.SEG_BYTES(SB), .LEN_W(16), .NSEG_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .st_pkts  (st_pkts),
    .st_drops (st_drops)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int nseg;
    int sum;
    int err;
  } desc_t;

  desc_t  exp_q[$];
  desc_t  got_log[$];
  int     total = 0;
  int     bad   = 0;
  bit     mon_en = 1'b0;

  // packet-level model state
  bit     in_pkt;
  int     m_len, m_nseg, m_sum, m_err;
  longint m_pkts, m_drops;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    in_pkt  = 1'b0;
    m_len   = 0; m_nseg = 0; m_sum = 0; m_err = 0;
    m_pkts  = 0; m_drops = 0;
  endtask

  task automatic model_seg(bit sop, bit eop, int vbc, logic [SB*8-1:0] data);
    int s = 0;
    bit ok = (vbc >= 1) && (vbc <= SB);
    desc_t d;
    if (ok) for (int k = 0; k < vbc; k++) s += int'(data[8*k +: 8]);
    if (!in_pkt && !sop) begin
      m_drops++;
      return;
    end
    if (sop) begin
      if (in_pkt) m_drops++;
      m_len = 0; m_nseg = 0; m_sum = 0; m_err = 0;
    end
    m_len += ok ? vbc : 0;
    if (m_len > 65535) begin m_len = 65535; m_err = 1; end
    m_nseg += 1;
    if (m_nseg > 255) begin m_nseg = 255; m_err = 1; end
    m_sum = (m_sum + s) % 65536;
    if (!ok) m_err = 1;
    if (eop) begin
      d = '{m_len, m_nseg, m_sum, m_err};
      exp_q.push_back(d);
      m_pkts++;
      in_pkt = 1'b0;
    end else begin
      in_pkt = 1'b1;
    end
  endtask

  // Compare DUT against the model, then fold in the events of the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("d_val", bus.d_val, exp_q.size() != 0);
      chk("i_ready", bus.i_ready, exp_q.size() < DEPTH);
      if (exp_q.size() != 0) begin
        chk("d_len",  bus.d_len,  exp_q[0].len);
        chk("d_nseg", bus.d_nseg, exp_q[0].nseg);
        chk("d_sum",  bus.d_sum,  exp_q[0].sum);
        chk("d_err",  bus.d_err,  exp_q[0].err);
      end
`ifdef C3PO_REASM_STATS_EN
      chk("st_pkts",  st_pkts,  m_pkts);
      chk("st_drops", st_drops, m_drops);
`else
      chk("st_pkts",  st_pkts,  0);
      chk("st_drops", st_drops, 0);
`endif
      if (reset) begin
        model_clear();
      end else begin
        if (bus.d_val === 1'b1 && bus.d_ready === 1'b1 && exp_q.size() != 0) begin
          got_log.push_back('{int'(bus.d_len), int'(bus.d_nseg), int'(bus.d_sum), int'(bus.d_err)});
          void'(exp_q.pop_front());
        end
        if (bus.i_val === 1'b1 && bus.i_ready === 1'b1)
          model_seg(bus.i_sop, bus.i_eop, int'(bus.i_vbc), bus.i_data);
      end
    end
  end

  function automatic logic [SB*8-1:0] d_fill(logic [7:0] b);
    logic [SB*8-1:0] r;
    for (int k = 0; k < SB; k++) r[8*k +: 8] = b;
    return r;
  endfunction

  function automatic logic [SB*8-1:0] d_ramp(int base);
    logic [SB*8-1:0] r;
    for (int k = 0; k < SB; k++) r[8*k +: 8] = 8'(base + k);
    return r;
  endfunction

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(bit sop, bit eop, int vbc, logic [SB*8-1:0] data);
    int n = 0;
    bus.i_val  = 1'b1;
    bus.i_sop  = sop;
    bus.i_eop  = eop;
    bus.i_vbc  = 6'(vbc);
    bus.i_data = data;
    do begin
      @(negedge clk);
      n++;
    end while (bus.i_ready !== 1'b1 && n < 300);
    chk("accept_in_time", bus.i_ready, 1);
    @(posedge clk);
    #1;
    bus.i_val = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || bus.d_val !== 1'b0) && n < 100);
    chk("drain_in_time", bus.d_val, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(string name, int idx, int len, int nseg, int sum, int err);
    desc_t d;
    d = got_log[idx];
    chk({name, "_len"},  d.len,  len);
    chk({name, "_nseg"}, d.nseg, nseg);
    chk({name, "_sum"},  d.sum,  sum);
    chk({name, "_err"},  d.err,  err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bus.i_val   = 1'b0;
    bus.i_sop   = 1'b0;
    bus.i_eop   = 1'b0;
    bus.i_vbc   = '0;
    bus.i_data  = '0;
    bus.d_ready = 1'b1;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    mon_en = 1'b1;
    #1;
    chk("reset_i_ready", bus.i_ready, 1);
    chk("reset_d_val",   bus.d_val,   0);
    chk("reset_d_len",   bus.d_len,   0);
    reset = 1'b0;

    // 1: five single-segment packets of all-ones bytes
    n0 = got_log.size();
    for (int i = 0; i < 5; i++) send(1, 1, 32, d_fill(8'h01));
    drain();
    chk("t1_count", got_log.size() - n0, 5);
    for (int i = 0; i < 5; i++) chk_log("t1", n0 + i, 32, 1, 32, 0);

    // 2: three-segment packet, byte k = k
    n0 = got_log.size();
    send(1, 0, 32, d_ramp(0));
    send(0, 0, 32, d_ramp(0));
    send(0, 1, 31, d_ramp(0));
    drain();
    chk("t2_count", got_log.size() - n0, 1);
    chk_log("t2", n0, 95, 3, 1457, 0);

    // 3: backpressure, FIFO fills after four descriptors
    n0 = got_log.size();
    bus.d_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(1, 1, i, d_fill(8'h02));
    chk("t3_full_i_ready", bus.i_ready, 0);
    chk("t3_full_d_len",   bus.d_len,   1);
    fork
      send(1, 1, 5, d_fill(8'h02));
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("t3_held_i_ready", bus.i_ready, 0);
        bus.d_ready = 1'b1;
      end
    join
    drain();
    chk("t3_count", got_log.size() - n0, 5);
    for (int i = 0; i < 5; i++) chk_log("t3", n0 + i, i + 1, 1, 2 * (i + 1), 0);

    // 4: sop, mid, then a fresh sop&eop aborts the open packet
    n0 = got_log.size();
    send(1, 0, 32, d_fill(8'h05));
    send(0, 0, 32, d_fill(8'h05));
    send(1, 1, 4, d_fill(8'h02));
    drain();
    chk("t4_count", got_log.size() - n0, 1);
    chk_log("t4", n0, 4, 1, 8, 0);
`ifdef C3PO_REASM_STATS_EN
    chk("t4_st_drops", st_drops, 1);
    chk("t4_st_pkts",  st_pkts,  12);
`else
    chk("t4_st_drops", st_drops, 0);
`endif

    // 5: orphan segment dropped; bad vbc flags the packet
    n0 = got_log.size();
    send(0, 1, 10, d_fill(8'h01));
    drain();
    chk("t5_orphan_count", got_log.size() - n0, 0);
`ifdef C3PO_REASM_STATS_EN
    chk("t5_st_drops", st_drops, 2);
`endif
    send(1, 0, 32, d_fill(8'h01));
    send(0, 0, 0,  d_fill(8'h01));
    send(0, 1, 8,  d_fill(8'h01));
    send(1, 1, 40, d_fill(8'h01));
    drain();
    chk("t5_count", got_log.size() - n0, 2);
    chk_log("t5a", n0,     40, 3, 40, 1);
    chk_log("t5b", n0 + 1, 0,  1, 0,  1);

    // 6: reset mid-packet with two descriptors queued
    n0 = got_log.size();
    bus.d_ready = 1'b0;
    send(1, 1, 8, d_fill(8'h01));
    send(1, 1, 9, d_fill(8'h01));
    send(1, 0, 32, d_fill(8'h07));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t6_d_val_after_reset",    bus.d_val,   0);
    chk("t6_i_ready_after_reset",  bus.i_ready, 1);
    chk("t6_st_drops_after_reset", st_drops,    0);
    bus.d_ready = 1'b1;
    send(1, 0, 16, d_ramp(0));
    send(0, 1, 16, d_ramp(16));
    drain();
    chk("t6_count", got_log.size() - n0, 1);
    chk_log("t6", n0, 32, 2, 496, 0);

    // 7: segment count saturates at 255
    n0 = got_log.size();
    send(1, 0, 1, d_fill(8'h03));
    for (int i = 0; i < 298; i++) send(0, 0, 1, d_fill(8'h03));
    send(0, 1, 1, d_fill(8'h03));
    drain();
    chk("t7_count", got_log.size() - n0, 1);
    chk_log("t7", n0, 300, 255, 900, 1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
